// File: rtl/reg_unit_pkg.sv
// reg_unit_pkg: shared mode/state types and config legality check for the scheduled register unit
package reg_unit_pkg;
   typedef enum logic [2:0] {REG_DFF = 3'd0, REG_DFFE = 3'd1, REG_SDFF = 3'd2, REG_SDFFE = 3'd3} mode_e;
   typedef enum logic [1:0] {UNCFG, CFGD, RUN, DRAIN} state_e;
   function automatic logic mode_is_legal(input logic [2:0] m);
      return !m[2];
   endfunction
endpackage

// File: rtl/reg_unit_sched_if.sv
// reg_unit_sched_if: config, schedule control and valid/ready datapath bundle of the register unit
interface reg_unit_sched_if #(parameter int WIDTH = 32, parameter int II_BITS = 4);
   logic               CFG_WE;
   logic [2:0]         CFG_MODE;
   logic [II_BITS-1:0] CFG_II;
   logic [WIDTH-1:0]   CFG_SRST_VALUE;
   logic               START;
   logic               STOP;
   logic               CLR;
   logic               IN_VALID;
   logic               IN_READY;
   logic [WIDTH-1:0]   D;
   logic               OUT_VALID;
   logic               OUT_READY;
   logic [WIDTH-1:0]   Q;
   logic               BUSY;
   logic               ERR;
   modport slave (
      input  CFG_WE, CFG_MODE, CFG_II, CFG_SRST_VALUE, START, STOP, CLR, IN_VALID, D, OUT_READY,
      output IN_READY, OUT_VALID, Q, BUSY, ERR
   );
   modport master (
      output CFG_WE, CFG_MODE, CFG_II, CFG_SRST_VALUE, START, STOP, CLR, IN_VALID, D, OUT_READY,
      input  IN_READY, OUT_VALID, Q, BUSY, ERR
   );
endinterface

// File: rtl/reg_unit_ii_counter.sv
// reg_unit_ii_counter: initiation-interval slot counter; ticks at zero and parks there while the slot is blocked
module reg_unit_ii_counter #(parameter int II_BITS = 4) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               en,
   input  logic               hold,
   input  logic [II_BITS-1:0] ii,
   output logic               tick
);
   logic [II_BITS-1:0] cnt_q, cnt_d;
   always_comb begin
      tick  = cnt_q == '0;
      cnt_d = load ? '0
            : (en && !(tick && hold)) ? ((cnt_q == ii) ? '0 : cnt_q + 1'b1)
            : cnt_q;
   end
   always_ff @(posedge clk)
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
endmodule

// File: rtl/reg_unit_sched.sv
// reg_unit_sched: configurable DFF/DFFE/SDFF/SDFFE register with II-paced capture slots and valid/ready handshakes
module reg_unit_sched import reg_unit_pkg::*; #(
   parameter int WIDTH   = 32,
   parameter int II_BITS = 4
) (
   input logic             CLK,
   input logic             RST,
   reg_unit_sched_if.slave bus
);
   state_e             state_q, state_d;
   mode_e              mode_q, mode_d;
   logic [II_BITS-1:0] ii_q, ii_d;
   logic [WIDTH-1:0]   srst_q, srst_d, q_q, q_d;
   logic               ov_q, ov_d, err_q, err_d;
   logic               tick, slot_free, in_ready, cfg_ok, want, fire, clr_eff, load, run;
   reg_unit_ii_counter #(.II_BITS(II_BITS)) u_cnt (
      .clk (CLK),
      .rst (RST),
      .load(load),
      .en  (run),
      .hold(!slot_free),
      .ii  (ii_q),
      .tick(tick)
   );
   always_comb begin
      run       = state_q == RUN;
      load      = state_q == CFGD && bus.START;
      slot_free = !ov_q || bus.OUT_READY;
      in_ready  = run && tick && slot_free;
      cfg_ok    = bus.CFG_WE && mode_is_legal(bus.CFG_MODE) && (state_q == UNCFG || state_q == CFGD);
      clr_eff   = bus.CLR && (mode_q == REG_SDFF || mode_q == REG_SDFFE);
      want      = (mode_q == REG_DFFE) ? bus.IN_VALID
                : (mode_q == REG_SDFFE) ? (bus.IN_VALID || bus.CLR)
                : 1'b1;
      // a STOP in the same cycle as a slot suppresses the capture
      fire      = in_ready && want && !bus.STOP;
      mode_d    = cfg_ok ? mode_e'(bus.CFG_MODE) : mode_q;
      ii_d      = cfg_ok ? bus.CFG_II : ii_q;
      srst_d    = cfg_ok ? bus.CFG_SRST_VALUE : srst_q;
      err_d     = err_q || (bus.CFG_WE && !cfg_ok);
      q_d       = fire ? (clr_eff ? srst_q : bus.D) : q_q;
      ov_d      = fire || (ov_q && !bus.OUT_READY);
      state_d   = cfg_ok ? CFGD
                : load ? RUN
                : (run && bus.STOP) ? DRAIN
                : (state_q == DRAIN && slot_free) ? CFGD
                : state_q;
   end
   always_ff @(posedge CLK)
      if (RST) begin
         state_q <= UNCFG;
         mode_q  <= REG_DFF;
         ii_q    <= '0;
         srst_q  <= '0;
         q_q     <= '0;
         ov_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         ii_q    <= ii_d;
         srst_q  <= srst_d;
         q_q     <= q_d;
         ov_q    <= ov_d;
         err_q   <= err_d;
      end
   assign bus.IN_READY  = in_ready;
   assign bus.OUT_VALID = ov_q;
   assign bus.Q         = q_q;
   assign bus.BUSY      = state_q == RUN || state_q == DRAIN;
   assign bus.ERR       = err_q;
endmodule
